// File: rtl/ras_pkg.sv
// Shared definitions for the return-address stack: jump opcodes, stack op
// classes and the RISC-V link-register hint test.
package ras_pkg;

    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    typedef enum logic [1:0] {RAS_NONE, RAS_PUSH, RAS_POP, RAS_POPPUSH} ras_op_e;

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

endpackage

// File: rtl/ras_stack_if.sv
// Request/response bundle between the fetch/jump path and the return-address stack.
interface ras_stack_if #(
    parameter int unsigned XLEN = 32
);
    logic            valid;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] imm_in;
    logic            ckpt_save;
    logic            ckpt_restore;
    logic [XLEN-1:0] pc_jmp;
    logic            muxras;
    logic            empty;
    logic            full;
    logic            overflow;
    logic            underflow;

    modport master (
        output valid, opcode, rd, rs1, rs1_val, pc_in, imm_in, ckpt_save, ckpt_restore,
        input  pc_jmp, muxras, empty, full, overflow, underflow
    );

    modport slave (
        input  valid, opcode, rd, rs1, rs1_val, pc_in, imm_in, ckpt_save, ckpt_restore,
        output pc_jmp, muxras, empty, full, overflow, underflow
    );
endinterface

// File: rtl/ras_classify.sv
// Combinational classification of a jump into a stack operation using the
// x1/x5 link-register hints.
module ras_classify
    import ras_pkg::*;
(
    input  logic       valid,
    input  logic [6:0] opcode,
    input  logic [4:0] rd,
    input  logic [4:0] rs1,
    output ras_op_e    op
);

    always_comb begin
        op = RAS_NONE;
        if (valid) begin
            if (opcode == OPC_JAL) begin
                if (is_link(rd)) op = RAS_PUSH;
            end else if (opcode == OPC_JALR) begin
                case ({is_link(rd), is_link(rs1)})
                    2'b01:   op = RAS_POP;
                    2'b10:   op = RAS_PUSH;
                    // Same link register on both sides is a call, not a coroutine swap.
                    2'b11:   op = (rd == rs1) ? RAS_PUSH : RAS_POPPUSH;
                    default: op = RAS_NONE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ras_stack.sv
// Circular return-address stack with one pointer checkpoint; outputs are
// registered and feed the PC select mux one cycle after the jump.
module ras_stack
    import ras_pkg::*;
#(
    parameter  int unsigned XLEN  = 32,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    ras_stack_if.slave   bus
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [XLEN-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] tos_q, tos_d, ckpt_tos_q, top_idx, wr_idx;
    logic [PTR_W:0]   count_q, count_d, ckpt_count_q;
    logic [XLEN-1:0]  pc_jmp_q, pc_jmp_d, push_tgt, ret_addr, jalr_sum;
    logic             muxras_q, muxras_d, ovf_q, ovf_d, unf_q, unf_d;
    logic             wr_en, do_push;
    ras_op_e          op;

    ras_classify u_classify (
        .valid  (bus.valid),
        .opcode (bus.opcode),
        .rd     (bus.rd),
        .rs1    (bus.rs1),
        .op     (op)
    );

    assign ret_addr = bus.pc_in + XLEN'(4);
    assign jalr_sum = bus.rs1_val + bus.imm_in;
    assign push_tgt = (bus.opcode == OPC_JAL) ? bus.pc_in + bus.imm_in
                                              : {jalr_sum[XLEN-1:1], 1'b0};
    assign top_idx  = tos_q - PTR_W'(1);

    always_comb begin
        tos_d    = tos_q;
        count_d  = count_q;
        pc_jmp_d = pc_jmp_q;
        muxras_d = 1'b0;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        wr_en    = 1'b0;
        wr_idx   = tos_q;
        do_push  = 1'b0;
        if (bus.ckpt_restore) begin
            // Restore drops any same-cycle op; entries themselves are not rolled back.
            tos_d   = ckpt_tos_q;
            count_d = ckpt_count_q;
        end else begin
            case (op)
                RAS_PUSH: do_push = 1'b1;
                RAS_POP: begin
                    if (count_q != '0) begin
                        pc_jmp_d = mem[top_idx];
                        tos_d    = top_idx;
                        count_d  = count_q - 1'b1;
                        muxras_d = 1'b1;
                    end else begin
                        unf_d = 1'b1;
                    end
                end
                RAS_POPPUSH: begin
                    if (count_q != '0) begin
                        pc_jmp_d = mem[top_idx];
                        wr_en    = 1'b1;
                        wr_idx   = top_idx;
                        muxras_d = 1'b1;
                    end else begin
                        do_push = 1'b1;
                        unf_d   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (do_push) begin
            wr_en    = 1'b1;
            tos_d    = tos_q + PTR_W'(1);
            pc_jmp_d = push_tgt;
            muxras_d = 1'b1;
            if (count_q == FULL_CNT) ovf_d = 1'b1;
            else count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= ret_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tos_q        <= '0;
            count_q      <= '0;
            ckpt_tos_q   <= '0;
            ckpt_count_q <= '0;
            pc_jmp_q     <= '0;
            muxras_q     <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            tos_q    <= tos_d;
            count_q  <= count_d;
            pc_jmp_q <= pc_jmp_d;
            muxras_q <= muxras_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            if (bus.ckpt_save && !bus.ckpt_restore) begin
                ckpt_tos_q   <= tos_q;
                ckpt_count_q <= count_q;
            end
        end
    end

    assign bus.pc_jmp    = pc_jmp_q;
    assign bus.muxras    = muxras_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    assign bus.empty     = (count_q == '0);
    assign bus.full      = (count_q == FULL_CNT);

endmodule

// File: doc/ras_stack.md
# ras_stack

Parametrised, synchronous return-address stack for the fetch/jump path of the RISC-V core. It classifies each JAL/JALR presented to it using the RISC-V link-register hint rules (x1/x5), pushes return addresses into a circular buffer of configurable depth, and pops predicted return targets. It also supports one speculative checkpoint/restore for branch-mispredict recovery. Its registered outputs drive the PC select mux in the same way the jump control path does.

## Interface
- XLEN, 32: address/data width.
- DEPTH, 16: stack entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH): pointer width (derived; do not override).
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- valid  in  1  one-cycle strobe: jump instruction present this cycle.
- opcode  in  7  instruction opcode.
- rd  in  5  destination register index.
- rs1  in  5  source register index.
- rs1_val  in  XLEN  value of register rs1 (JALR base).
- pc_in  in  XLEN  PC of the jump instruction.
- imm_in  in  XLEN  sign-extended immediate.
- ckpt_save  in  1  snapshot the pointer state.
- ckpt_restore  in  1  restore the pointer state from the snapshot.
- pc_jmp  out  XLEN  predicted/computed target.
- muxras  out  1  1 = PC mux selects pc_jmp.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  one-cycle pulse: a push overwrote the oldest entry.
- underflow  out  1  one-cycle pulse: a pop was attempted while empty.

## Operation
- link(r) = (r == 1) || (r == 5). Requests with valid=0, or with an opcode other than JAL (1101111) or JALR (1100111), are class NONE.
- JAL: link(rd) gives PUSH. Otherwise NONE.
- JALR, classified on link(rd) and link(rs1):
  - !rd, !rs1 gives NONE.
  - !rd, rs1 gives POP.
  - rd, !rs1 gives PUSH.
  - rd, rs1 with rd == rs1 gives PUSH.
  - rd, rs1 with rd != rs1 gives POPPUSH.
- Targets:
  - JAL push target: pc_in + imm_in.
  - JALR push target: (rs1_val + imm_in) with bit 0 cleared.
  - All sums are modulo 2^XLEN.
- Return address written on PUSH and POPPUSH: pc_in + 4.
- State:
  - mem[DEPTH]: not reset.
  - tos: index of the next free slot.
  - count: 0..DEPTH.
  - ckpt_tos, ckpt_count: snapshot registers.
- PUSH: mem[tos] <= pc_in+4; tos <= tos+1, wrapping at DEPTH. If count == DEPTH, count holds and overflow pulses (oldest entry lost). Otherwise count+1. Outputs: pc_jmp = push target, muxras = 1.
- POP, count > 0: pc_jmp = mem[tos-1]; tos-1, wrapping; count-1; muxras = 1.
- POP, count == 0: tos and count unchanged; underflow pulses; muxras = 0; pc_jmp holds its previous value.
- POPPUSH, count > 0: pc_jmp = mem[tos-1]; mem[tos-1] <= pc_in+4; tos and count unchanged; muxras = 1.
- POPPUSH, count == 0: behaves as PUSH with the JALR target, and underflow pulses.
- NONE: stack unchanged; muxras = 0; pc_jmp holds.
- ckpt_save: ckpt_tos/ckpt_count <= tos/count as they stand before any same-cycle operation.
- ckpt_restore: tos/count <= ckpt_tos/ckpt_count. It has priority over any same-cycle valid op, which is dropped (muxras = 0, no flags). Entries are never restored.
- ckpt_save together with ckpt_restore in the same cycle: the restore wins and the snapshot is left unchanged.

## Timing
- Reset values:
  - tos = 0, count = 0, ckpt_tos = 0, ckpt_count = 0.
  - pc_jmp = 0, muxras = 0, overflow = 0, underflow = 0.
  - empty = 1, full = 0.
- Latency: an op presented in cycle N has its pc_jmp, muxras, overflow and underflow registered and visible in cycle N+1.
- muxras, overflow and underflow are single-cycle pulses.
- empty and full are combinational from count and reflect state after the edge.
- Back-to-back valid ops every cycle are supported. A POP in cycle N+1 observes a PUSH made in cycle N; the write occurs at the edge, so no bypass is needed.
- Reset asserted mid-stream clears all pointers and outputs immediately. Stale mem contents are unreachable because count = 0.

## Structure
- Shared package ras_pkg holds:
  - OPC_JAL and OPC_JALR constants.
  - Enum ras_op_e {RAS_NONE, RAS_PUSH, RAS_POP, RAS_POPPUSH}.
  - Function is_link(input [4:0] r).
- Sub-module ras_classify: purely combinational. Inputs are valid, opcode, rd and rs1; output is ras_op_e. It is instantiated once.
- The top level holds the memory array, pointers, snapshot registers and output registers.

## Test plan
- Reset release with no ops: pc_jmp=0, muxras=0, empty=1, full=0.
- JAL rd=1, pc=0x100, imm=0x40, then JALR rd=0 rs1=1. Cycle after the JAL: pc_jmp=0x140, muxras=1. Cycle after the JALR: pc_jmp=0x104, muxras=1, empty=1.
- DEPTH=4: five JAL rd=1 pushes at pc=0x0, 0x10, 0x20, 0x30, 0x40. The fifth gives overflow=1 and full=1. Four pops then return 0x44, 0x34, 0x24, 0x14. A fifth pop gives underflow=1, muxras=0.
- JALR rd=5 rs1=1 on a stack holding 0x204, pc=0x300: pc_jmp=0x204, stack top becomes 0x304, count unchanged.
- JALR rd=1 rs1=6, rs1_val=0x1001, imm=0x10, pc=0x500: pc_jmp=0x1010, pushes 0x504.
- ckpt_save at count=2, then two pushes, then ckpt_restore with a simultaneous valid pop: the pop is dropped (muxras=0) and count=2. The next pop returns the entry at the restored top of stack.
